// File: rtl/data_mem_mover.sv
// data_mem_mover
//   Second initiator on the single-cycle data memory port. It performs block
//   copy (memory to memory, ascending) and block fill (constant to memory)
//   under a Start / Busy / Done handshake.
//
//   Ports
//     CLK, RST       clock (rising edge), asynchronous active-high reset
//     Start          request, sampled only while idle
//     Mode           0 = copy, 1 = fill
//     Src_Addr       copy source base word address
//     Dst_Addr       destination base word address
//     Length         word count
//     Fill_Value     constant written in fill mode
//     A_Data         memory address
//     WE             memory write enable
//     WD             memory write data
//     RD             memory read data (combinational from A_Data)
//     Busy           transfer in progress (CHECK, READ, WRITE)
//     Done           one-cycle completion pulse
//     Err            range error flag for the last request
//     Words_Done     words written in the current/last request
module data_mem_mover #(
  parameter int Data_Memory_Width = 32,
  parameter int Data_Memory_Depth = 100,
  parameter int Len_Width         = 8
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         Start,
  input  logic                         Mode,
  input  logic [Data_Memory_Width-1:0] Src_Addr,
  input  logic [Data_Memory_Width-1:0] Dst_Addr,
  input  logic [Len_Width-1:0]         Length,
  input  logic [Data_Memory_Width-1:0] Fill_Value,
  output logic [Data_Memory_Width-1:0] A_Data,
  output logic                         WE,
  output logic [Data_Memory_Width-1:0] WD,
  input  logic [Data_Memory_Width-1:0] RD,
  output logic                         Busy,
  output logic                         Done,
  output logic                         Err,
  output logic [Len_Width-1:0]         Words_Done
);

  localparam int W = Data_Memory_Width;
  localparam int L = Len_Width;
  localparam logic [W:0] LIMIT = (W+1)'(Data_Memory_Depth);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_READ  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;

  logic           r_mode;
  logic [W-1:0]   r_src;
  logic [W-1:0]   r_dst;
  logic [L-1:0]   r_len;
  logic [W-1:0]   r_fill;
  logic [W-1:0]   r_hold;
  logic [L-1:0]   r_idx;
  logic [L-1:0]   r_words_done;
  logic           r_err;

  logic [W:0]     w_dst_end;
  logic [W:0]     w_src_end;
  logic           w_range_err;
  logic [L-1:0]   w_idx_nxt;
  logic           w_last;
  logic [W-1:0]   w_idx_ext;

  // One extra bit on the end-address sums so a base near the top of the
  // address space cannot wrap around and pass the range test.
  assign w_dst_end   = {1'b0, r_dst} + {{(W+1-L){1'b0}}, r_len};
  assign w_src_end   = {1'b0, r_src} + {{(W+1-L){1'b0}}, r_len};
  assign w_range_err = (w_dst_end > LIMIT) || (!r_mode && (w_src_end > LIMIT));
  assign w_idx_nxt   = r_idx + 1'b1;
  assign w_last      = (w_idx_nxt == r_len);
  assign w_idx_ext   = {{(W-L){1'b0}}, r_idx};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (Start) w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (w_range_err || (r_len == '0)) w_state_nxt = S_DONE;
        else if (r_mode)                  w_state_nxt = S_WRITE;
        else                              w_state_nxt = S_READ;
      end
      S_READ: begin
        w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        if (w_last)      w_state_nxt = S_DONE;
        else if (r_mode) w_state_nxt = S_WRITE;
        else             w_state_nxt = S_READ;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Memory port outputs decode from registered state only; Start never
  // reaches them combinationally. WE is additionally gated by RST so a
  // reset mid-write drops the enable without waiting for the state flop.
  always_comb begin
    A_Data = '0;
    WE     = 1'b0;
    WD     = '0;
    Busy   = 1'b0;
    Done   = 1'b0;
    case (r_state)
      S_CHECK: begin
        Busy = 1'b1;
      end
      S_READ: begin
        Busy   = 1'b1;
        A_Data = r_src + w_idx_ext;
      end
      S_WRITE: begin
        Busy   = 1'b1;
        A_Data = r_dst + w_idx_ext;
        WE     = ~RST;
        WD     = r_mode ? r_fill : r_hold;
      end
      S_DONE: begin
        Done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_mode       <= 1'b0;
      r_src        <= '0;
      r_dst        <= '0;
      r_len        <= '0;
      r_fill       <= '0;
      r_hold       <= '0;
      r_idx        <= '0;
      r_words_done <= '0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_mode       <= Mode;
            r_src        <= Src_Addr;
            r_dst        <= Dst_Addr;
            r_len        <= Length;
            r_fill       <= Fill_Value;
            r_idx        <= '0;
            r_words_done <= '0;
            r_err        <= 1'b0;
          end
        end
        S_CHECK: begin
          if (w_range_err) r_err <= 1'b1;
        end
        S_READ: begin
          r_hold <= RD;
        end
        S_WRITE: begin
          r_idx        <= w_idx_nxt;
          r_words_done <= r_words_done + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign Err        = r_err;
  assign Words_Done = r_words_done;

endmodule

// File: tb/tb_data_mem_mover.sv
module tb_data_mem_mover;

  localparam int W     = 32;
  localparam int DEPTH = 100;
  localparam int L     = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic [W-1:0] src = '0;
  logic [W-1:0] dst = '0;
  logic [L-1:0] len = '0;
  logic [W-1:0] fillv = '0;
  logic [W-1:0] a_data;
  logic         we;
  logic [W-1:0] wd;
  logic [W-1:0] rd;
  logic         busy;
  logic         done;
  logic         err;
  logic [L-1:0] words_done;

  always #5 clk = ~clk;

  data_mem_mover #(
    .Data_Memory_Width(W),
    .Data_Memory_Depth(DEPTH),
    .Len_Width(L)
  ) dut (
    .CLK(clk), .RST(rst), .Start(start), .Mode(mode),
    .Src_Addr(src), .Dst_Addr(dst), .Length(len), .Fill_Value(fillv),
    .A_Data(a_data), .WE(we), .WD(wd), .RD(rd),
    .Busy(busy), .Done(done), .Err(err), .Words_Done(words_done)
  );

  // Bench memory (what the DUT really writes) and model memory (what it should hold)
  logic [W-1:0] mem [0:DEPTH-1];
  logic [W-1:0] mm  [0:DEPTH-1];
  logic         do_load = 1'b0;

  assign rd = (a_data < 32'(DEPTH)) ? mem[a_data[6:0]] : '0;

  always @(posedge clk) begin
    if (do_load) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= mm[i];
    end else if (we && (a_data < 32'(DEPTH))) begin
      mem[a_data[6:0]] <= wd;
    end
  end

  typedef struct {
    logic         busy;
    logic         we;
    logic         done;
    logic         err;
    logic [W-1:0] a;
    logic [W-1:0] wd;
    logic [L-1:0] wdn;
  } exp_t;

  exp_t         expq[$];
  int           errors = 0;
  int           checks = 0;
  bit           chk_en = 1'b0;
  logic         m_err = 1'b0;
  logic [L-1:0] m_wdone = '0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic b, input logic w, input logic d, input logic e,
                      input logic [W-1:0] a, input logic [W-1:0] v, input logic [L-1:0] n);
    exp_t x;
    x.busy = b; x.we = w; x.done = d; x.err = e; x.a = a; x.wd = v; x.wdn = n;
    expq.push_back(x);
  endtask

  // Single per-cycle compare process: one expected entry per cycle while a
  // request is in flight, idle outputs otherwise.
  always @(negedge clk) begin : cmp
    exp_t e;
    if (chk_en && !rst) begin
      if (expq.size() > 0) begin
        e = expq.pop_front();
      end else begin
        e.busy = 1'b0; e.we = 1'b0; e.done = 1'b0; e.err = m_err;
        e.a = '0; e.wd = '0; e.wdn = m_wdone;
      end
      chk("busy", W'(busy), W'(e.busy));
      chk("we", W'(we), W'(e.we));
      chk("done", W'(done), W'(e.done));
      chk("err", W'(err), W'(e.err));
      chk("a_data", a_data, e.a);
      chk("wd", wd, e.wd);
      chk("words_done", W'(words_done), W'(e.wdn));
    end
  end

  task automatic mem_compare(input string name);
    int bad;
    bad = -1;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== mm[i] && bad < 0) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: mem[%0d] got %0h expected %0h", name, bad, mem[bad], mm[bad]);
    end
  endtask

  // Issues one request and builds the expected per-cycle trace from the
  // transfer rules (range check, ascending word-by-word copy/fill).
  task automatic run_req(input logic md, input logic [W-1:0] s, input logic [W-1:0] d,
                         input logic [L-1:0] n, input logic [W-1:0] fv, input bit glitch,
                         output int done_cyc, output int we_cnt, output int done_cnt);
    logic         e_err;
    logic [W-1:0] v;
    @(posedge clk); #1;
    start = 1'b1; mode = md; src = s; dst = d; len = n; fillv = fv;
    push(1'b0, 1'b0, 1'b0, m_err, '0, '0, m_wdone);
    push(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    e_err = (({1'b0, d} + 33'(n)) > 33'(DEPTH)) ||
            (!md && (({1'b0, s} + 33'(n)) > 33'(DEPTH)));
    if (e_err || n == 0) begin
      push(1'b0, 1'b0, 1'b1, e_err, '0, '0, '0);
      m_err = e_err; m_wdone = '0;
    end else begin
      for (int i = 0; i < int'(n); i++) begin
        if (!md) begin
          v = mm[s + i];
          push(1'b1, 1'b0, 1'b0, 1'b0, s + i, '0, L'(i));
        end else begin
          v = fv;
        end
        push(1'b1, 1'b1, 1'b0, 1'b0, d + i, v, L'(i));
        mm[d + i] = v;
      end
      push(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, n);
      m_err = 1'b0; m_wdone = n;
    end
    @(posedge clk); #1;
    start = 1'b0;
    done_cyc = -1; we_cnt = 0; done_cnt = 0;
    for (int cyc = 1; cyc <= 2 * int'(n) + 5; cyc++) begin
      if (glitch && cyc == 2) begin
        start = 1'b1; mode = ~md; src = $urandom; dst = $urandom;
        len = L'($urandom); fillv = $urandom;
      end
      if (glitch && cyc == 3) start = 1'b0;
      if (we) we_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      @(posedge clk); #1;
    end
    mem_compare("mem");
  endtask

  initial begin
    int dc, wc, dn, exp_dc;
    logic         md;
    logic [W-1:0] s, d, fv;
    logic [L-1:0] n;
    bit           e;

    // Reset state
    #12;
    chk("rst a_data", a_data, '0);
    chk("rst we", W'(we), '0);
    chk("rst wd", wd, '0);
    chk("rst busy", W'(busy), '0);
    chk("rst done", W'(done), '0);
    chk("rst err", W'(err), '0);
    chk("rst words_done", W'(words_done), '0);

    for (int i = 0; i < DEPTH; i++) mm[i] = $urandom;
    mm[0] = 32'd1; mm[1] = 32'd2; mm[2] = 32'd3;
    mm[98] = 32'h1234_5678; mm[99] = 32'h9ABC_DEF0;
    @(posedge clk); #1; do_load = 1'b1;
    @(posedge clk); #1; do_load = 1'b0; rst = 1'b0; chk_en = 1'b1;

    // Fill 4 words at 10
    run_req(1'b1, 32'd0, 32'd10, 8'd4, 32'hA5A5_0001, 1'b0, dc, wc, dn);
    chk("fill done cycle", W'(dc), 32'd6);
    chk("fill we count", W'(wc), 32'd4);
    chk("fill words_done", W'(words_done), 32'd4);
    chk("fill err", W'(err), 32'd0);
    for (int i = 10; i < 14; i++) chk("fill word", mem[i], 32'hA5A5_0001);

    // Copy 0..2 -> 50..52
    run_req(1'b0, 32'd0, 32'd50, 8'd3, 32'd0, 1'b0, dc, wc, dn);
    chk("copy done cycle", W'(dc), 32'd8);
    chk("copy we count", W'(wc), 32'd3);
    chk("copy mem50", mem[50], 32'd1);
    chk("copy mem51", mem[51], 32'd2);
    chk("copy mem52", mem[52], 32'd3);

    // Zero length copy
    run_req(1'b0, 32'd5, 32'd20, 8'd0, 32'd0, 1'b0, dc, wc, dn);
    chk("len0 done cycle", W'(dc), 32'd2);
    chk("len0 we count", W'(wc), 32'd0);
    chk("len0 err", W'(err), 32'd0);
    chk("len0 words_done", W'(words_done), 32'd0);

    // Range error on fill
    run_req(1'b1, 32'd0, 32'd98, 8'd3, 32'hDEAD_BEEF, 1'b0, dc, wc, dn);
    chk("range err", W'(err), 32'd1);
    chk("range done cycle", W'(dc), 32'd2);
    chk("range we count", W'(wc), 32'd0);
    chk("range mem98", mem[98], 32'h1234_5678);
    chk("range mem99", mem[99], 32'h9ABC_DEF0);

    // Destination near top of address space must not wrap past the check
    run_req(1'b1, 32'd0, 32'hFFFF_FFFE, 8'd4, 32'h1, 1'b0, dc, wc, dn);
    chk("wrap err", W'(err), 32'd1);
    chk("wrap we count", W'(wc), 32'd0);

    // Start pulsed during a 4-word fill
    run_req(1'b1, 32'd0, 32'd70, 8'd4, 32'h0BAD_F00D, 1'b1, dc, wc, dn);
    chk("glitch we count", W'(wc), 32'd4);
    chk("glitch done pulses", W'(dn), 32'd1);

    // Overlapping ascending copy (destination above source)
    run_req(1'b0, 32'd30, 32'd32, 8'd5, 32'd0, 1'b0, dc, wc, dn);
    chk("overlap done cycle", W'(dc), 32'd12);

    // Reset in the middle of a 5-word copy, after 2 words written
    chk_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; mode = 1'b0; src = 32'd20; dst = 32'd60; len = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("pre-rst we", W'(we), 32'd1);
    chk("pre-rst a_data", a_data, 32'd62);
    rst = 1'b1;
    #1;
    chk("mid-rst we", W'(we), 32'd0);
    chk("mid-rst busy", W'(busy), 32'd0);
    chk("mid-rst words_done", W'(words_done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mm[60] = mm[20]; mm[61] = mm[21];
    mem_compare("mem after rst");
    m_err = 1'b0; m_wdone = '0;
    expq.delete();
    chk_en = 1'b1;
    run_req(1'b0, 32'd20, 32'd60, 8'd5, 32'd0, 1'b0, dc, wc, dn);
    chk("post-rst done cycle", W'(dc), 32'd12);
    chk("post-rst words_done", W'(words_done), 32'd5);

    // Randomized requests
    for (int k = 0; k < 40; k++) begin
      md = 1'($urandom_range(0, 1));
      s  = $urandom_range(0, 105);
      d  = $urandom_range(0, 105);
      if ($urandom_range(0, 9) == 0)      n = '0;
      else if ($urandom_range(0, 7) == 0) n = L'($urandom_range(60, 200));
      else                                n = L'($urandom_range(1, 12));
      fv = $urandom;
      e  = ((d + n) > DEPTH) || (!md && ((s + n) > DEPTH));
      run_req(md, s, d, n, fv, 1'b0, dc, wc, dn);
      if (e || n == 0) exp_dc = 2;
      else if (md)     exp_dc = int'(n) + 2;
      else             exp_dc = 2 * int'(n) + 2;
      chk("rand done cycle", W'(dc), W'(exp_dc));
      chk("rand done pulses", W'(dn), 32'd1);
      chk("rand we count", W'(wc), (e || n == 0) ? 32'd0 : W'(n));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_mover.md
# data_mem_mover

Memory-side initiator for the single-cycle data memory port. It drives address, write-enable and write-data, and consumes the combinational read data. It performs block copy (memory→memory) and block fill (constant→memory) under a start/busy/done handshake. It sits beside the datapath as a second master on the data memory port; the top-level mux grants the port to this block while Busy is high.

## Interface
- Data_Memory_Width, 32, data and address width
- Data_Memory_Depth, 100, number of words in the target memory; used for range checking
- Len_Width, 8, width of the Length operand

- CLK  input  1  clock, rising edge
- RST  input  1  asynchronous, active-high reset
- Start  input  1  request; sampled only in IDLE
- Mode  input  1  0 = copy, 1 = fill
- Src_Addr  input  Data_Memory_Width  copy source base word address
- Dst_Addr  input  Data_Memory_Width  destination base word address
- Length  input  Len_Width  word count
- Fill_Value  input  Data_Memory_Width  fill data
- A_Data  output  Data_Memory_Width  memory address
- WE  output  1  memory write enable
- WD  output  Data_Memory_Width  memory write data
- RD  input  Data_Memory_Width  memory read data, combinational from A_Data
- Busy  output  1  transfer in progress
- Done  output  1  one-cycle completion pulse
- Err  output  1  range error flag for last request
- Words_Done  output  Len_Width  words written in current/last request

## Operation
- States: IDLE, CHECK, READ, WRITE, DONE.
- IDLE: Start=1 latches Mode, Src_Addr, Dst_Addr, Length, Fill_Value. It clears Err and Words_Done, then goes to CHECK. Start is ignored in every other state.
- CHECK, one cycle: range test uses Data_Memory_Width+1 bit sums.
  - Error if Dst+Length > Depth.
  - In copy mode, error also if Src+Length > Depth.
  - On error: set Err and go to DONE with no memory access.
  - If Length==0: go to DONE, Err stays 0.
  - Otherwise: copy goes to READ, fill goes to WRITE.
- READ (copy only): A_Data=Src+i, WE=0. At the clock edge, RD is captured into the hold register. Next state is WRITE.
- WRITE: A_Data=Dst+i, WE=1.
  - WD is the hold register in copy mode, Fill_Value in fill mode.
  - At the clock edge, i and Words_Done increment.
  - If i+1==Length, go to DONE. Otherwise copy goes to READ and fill stays in WRITE.
- DONE, one cycle: Done=1, then IDLE.
- Copy is always ascending. If a destination overlaps above the source, already-written words are re-read; this is defined behaviour and is not corrected.
- Outside READ/WRITE: A_Data=0, WE=0, WD=0.
- Busy=1 in CHECK, READ and WRITE.

## Timing
- Reset values: state IDLE, A_Data=0, WE=0, WD=0, Busy=0, Done=0, Err=0, Words_Done=0, hold register 0.
- RST high mid-transfer forces WE=0 immediately, without waiting for a clock edge. Writes already committed remain in memory; no partial-word write is possible.
- All outputs are decoded from registered state and counters. There is no combinational path from Start to any output.
- Start accepted at edge E0 gives Busy=1 after E0, and CHECK occupies cycle 1.
- Copy of N≥1 words: READ/WRITE pairs occupy cycles 2..2N+1, and Done is high in cycle 2N+2.
- Fill of N≥1 words: WRITE occupies cycles 2..N+1, and Done is high in cycle N+2.
- Length 0 or range error: Done is high in cycle 2.
- Err and Words_Done hold their values after DONE until the next accepted Start.
- Back-to-back: Start held high during DONE is ignored. It is accepted at the first edge in IDLE, so the minimum gap between requests is one IDLE cycle.

## Test plan
- Fill: Dst=10, Length=4, Fill_Value=0xA5A5_0001 → words 10..13 = 0xA5A5_0001. WE high in cycles 2..5, Done in cycle 6, Words_Done=4, Err=0.
- Copy: preload mem[0..2]=1,2,3; Src=0, Dst=50, Length=3 → mem[50..52]=1,2,3. WE pattern 0,1,0,1,0,1 in cycles 2..7, Done in cycle 8.
- Length=0 (copy) → no WE at any cycle, Done in cycle 2, Err=0, Words_Done=0.
- Range error: Dst=98, Length=3, fill → Err=1, Done in cycle 2, WE never high, mem[98..99] unchanged.
- Start pulsed again during a 4-word fill → ignored; exactly 4 writes occur and only one Done pulse is produced.
- RST asserted mid-copy after 2 of 5 words → WE drops before the next edge. Busy=0, Words_Done=0, mem[Dst+0..1] written, mem[Dst+2..4] untouched. A new Start afterwards completes normally.
